// File: rtl/key_event_queue.sv
// key_event_queue: watches a packed USB keycode word for programmable keys and
// queues press / release / auto-repeat events into a first-word-fall-through FIFO.
module key_event_queue #(
  parameter int NUM_SLOTS    = 2,
  parameter int NUM_WATCH    = 8,
  parameter int FIFO_DEPTH   = 8,
  parameter int REPEAT_EN    = 1,
  parameter int REPEAT_DELAY = 30,
  parameter int REPEAT_RATE  = 6
) (
  input  logic                          Clk,
  input  logic                          Reset_n,
  input  logic [8*NUM_SLOTS-1:0]        keycode,
  input  logic                          frame_clk,
  input  logic [8*NUM_WATCH-1:0]        watch_codes,
  output logic [NUM_WATCH-1:0]          pressed,
  output logic                          evt_valid,
  output logic [7:0]                    evt_code,
  output logic [1:0]                    evt_type,
  input  logic                          evt_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          clr_overflow
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CW   = PW + 1;
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam int GW   = (NUM_WATCH > 1) ? $clog2(NUM_WATCH) : 1;

  typedef enum logic [1:0] {
    EVT_NONE    = 2'b00,
    EVT_PRESS   = 2'b01,
    EVT_RELEASE = 2'b10,
    EVT_REPEAT  = 2'b11
  } evt_kind_e;

  logic [NUM_WATCH-1:0] cur;
  logic [NUM_WATCH-1:0] press_edge;
  logic [NUM_WATCH-1:0] release_edge;
  logic [NUM_WATCH-1:0] rep_hit;
  logic [NUM_WATCH-1:0] pvalid;
  logic [NUM_WATCH-1:0] taken;
  evt_kind_e            ptype [NUM_WATCH];
  logic [RW-1:0]        rcnt  [NUM_WATCH];

  logic          fs_meta, fs_sync, fs_prev, tick;
  logic [GW-1:0] grant;
  logic          any_pend, full, push, pop, ovf_set;
  logic [7:0]    push_code;
  logic [9:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;

  // Match each watched code against every keycode slot; code 0x00 disables an index
  always_comb begin
    cur = '0;
    for (int unsigned i = 0; i < NUM_WATCH; i++) begin
      if (watch_codes[8*i +: 8] != 8'h00) begin
        for (int unsigned s = 0; s < NUM_SLOTS; s++) begin
          if (keycode[8*s +: 8] == watch_codes[8*i +: 8]) cur[i] = 1'b1;
        end
      end
    end
  end

  assign press_edge   = cur & ~pressed;
  assign release_edge = ~cur & pressed;

  // Registered key bitmap
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) pressed <= '0;
    else          pressed <= cur;
  end

  // Synchronise frame_clk and keep the previous synced value for edge detection
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      fs_meta <= 1'b0;
      fs_sync <= 1'b0;
      fs_prev <= 1'b0;
    end else begin
      fs_meta <= frame_clk;
      fs_sync <= fs_meta;
      fs_prev <= fs_sync;
    end
  end

  assign tick = fs_sync & ~fs_prev;

  // A repeat fires on the tick that finds a held key's counter at 1
  always_comb begin
    rep_hit = '0;
    for (int unsigned i = 0; i < NUM_WATCH; i++) begin
      rep_hit[i] = (REPEAT_EN != 0) && tick && cur[i] && pressed[i] && (rcnt[i] == RW'(1));
    end
  end

  // Per-key repeat counters: load on press, clear when not held, count down on ticks
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int unsigned i = 0; i < NUM_WATCH; i++) rcnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_WATCH; i++) begin
        if (REPEAT_EN == 0)           rcnt[i] <= '0;
        else if (press_edge[i])       rcnt[i] <= RW'(REPEAT_DELAY);
        else if (!cur[i])             rcnt[i] <= '0;
        else if (tick) begin
          if (rep_hit[i])             rcnt[i] <= RW'(REPEAT_RATE);
          else if (rcnt[i] != '0)     rcnt[i] <= rcnt[i] - RW'(1);
        end
      end
    end
  end

  // Lowest-index pending slot wins the single push per cycle
  always_comb begin
    grant    = '0;
    any_pend = 1'b0;
    for (int unsigned i = NUM_WATCH; i > 0; i--) begin
      if (pvalid[i-1]) begin
        grant    = GW'(i - 1);
        any_pend = 1'b1;
      end
    end
  end

  assign full      = (fifo_count == CW'(FIFO_DEPTH));
  assign pop       = evt_valid & evt_ready;
  assign push      = any_pend & (~full | pop);
  assign push_code = watch_codes[8*grant +: 8];

  // A slot being pushed this cycle is free, so a new edge on it is not an overwrite
  always_comb begin
    taken = '0;
    for (int unsigned i = 0; i < NUM_WATCH; i++) taken[i] = push && (grant == GW'(i));
    ovf_set = |((press_edge | release_edge) & pvalid & ~taken);
  end

  // Pending slots: edges overwrite, repeats only fill an empty slot, push clears
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      pvalid <= '0;
      for (int unsigned i = 0; i < NUM_WATCH; i++) ptype[i] <= EVT_NONE;
    end else begin
      for (int unsigned i = 0; i < NUM_WATCH; i++) begin
        if (press_edge[i] || release_edge[i]) begin
          pvalid[i] <= 1'b1;
          ptype[i]  <= press_edge[i] ? EVT_PRESS : EVT_RELEASE;
        end else if (rep_hit[i] && !(pvalid[i] && !taken[i])) begin
          pvalid[i] <= 1'b1;
          ptype[i]  <= EVT_REPEAT;
        end else if (taken[i]) begin
          pvalid[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky overflow flag; clear takes priority over a same-cycle set
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)          overflow <= 1'b0;
    else if (clr_overflow) overflow <= 1'b0;
    else if (ovf_set)      overflow <= 1'b1;
  end

  // FIFO storage, entry = {code, type}
  always_ff @(posedge Clk) begin
    if (push) mem[wr_ptr] <= {push_code, ptype[grant]};
  end

  // FIFO pointers and occupancy
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Head presentation; outputs read as zero while empty
  always_comb begin
    evt_valid = (fifo_count != '0);
    evt_code  = '0;
    evt_type  = '0;
    if (evt_valid) begin
      evt_code = mem[rd_ptr][9:2];
      evt_type = mem[rd_ptr][1:0];
    end
  end

endmodule

// File: tb/tb_key_event_queue.sv
// Testbench for key_event_queue: directed scenarios plus randomized traffic,
// checked against a behavioural model and an expected-event scoreboard.
module tb_key_event_queue;

  localparam int NS = 2;
  localparam int NW = 8;
  localparam int DEPTH = 8;
  localparam int RD = 3;
  localparam int RR = 2;

  logic              Clk = 1'b0;
  logic              Reset_n;
  logic [8*NS-1:0]   keycode;
  logic              frame_clk;
  logic [8*NW-1:0]   watch_codes;
  logic [NW-1:0]     pressed;
  logic              evt_valid;
  logic [7:0]        evt_code;
  logic [1:0]        evt_type;
  logic              evt_ready;
  logic [$clog2(DEPTH):0] fifo_count;
  logic              overflow;
  logic              clr_overflow;

  key_event_queue #(
    .NUM_SLOTS(NS), .NUM_WATCH(NW), .FIFO_DEPTH(DEPTH),
    .REPEAT_EN(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .Clk(Clk), .Reset_n(Reset_n), .keycode(keycode), .frame_clk(frame_clk),
    .watch_codes(watch_codes), .pressed(pressed), .evt_valid(evt_valid),
    .evt_code(evt_code), .evt_type(evt_type), .evt_ready(evt_ready),
    .fifo_count(fifo_count), .overflow(overflow), .clr_overflow(clr_overflow)
  );

  always #5 Clk = ~Clk;

  int errors = 0;
  int checks = 0;
  int n_rep  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  bit [NW-1:0] m_pressed;
  bit          m_pv [NW];
  bit [1:0]    m_pt [NW];
  int          m_rc [NW];
  int          m_count;
  bit          m_ovf;
  bit [2:0]    m_hist;          // frame_clk samples from the last three edges, newest in bit 0
  logic [9:0]  exp_q [$];       // expected {code, type} in FIFO order

  task automatic model_reset();
    m_pressed = '0;
    for (int i = 0; i < NW; i++) begin
      m_pv[i] = 1'b0; m_pt[i] = 2'b00; m_rc[i] = 0;
    end
    m_count = 0; m_ovf = 1'b0; m_hist = '0;
    exp_q.delete();
  endtask

  task automatic model_step();
    bit [NW-1:0] cur;
    bit tick, pop, push;
    int g;
    logic [7:0] w;
    cur = '0;
    for (int i = 0; i < NW; i++) begin
      w = watch_codes[8*i +: 8];
      if (w != 8'h00)
        for (int s = 0; s < NS; s++)
          if (keycode[8*s +: 8] == w) cur[i] = 1'b1;
    end
    tick = m_hist[1] & ~m_hist[2];
    m_hist = {m_hist[1:0], frame_clk};
    g = -1;
    for (int i = NW - 1; i >= 0; i--) if (m_pv[i]) g = i;
    pop  = (m_count > 0) && evt_ready;
    push = (g >= 0) && ((m_count < DEPTH) || pop);
    if (push) begin
      exp_q.push_back({watch_codes[8*g +: 8], m_pt[g]});
      m_pv[g] = 1'b0;
    end
    for (int i = 0; i < NW; i++) begin
      bit pe, re, rep;
      pe  = cur[i] && !m_pressed[i];
      re  = !cur[i] && m_pressed[i];
      rep = 1'b0;
      if (pe) m_rc[i] = RD;
      else if (!cur[i]) m_rc[i] = 0;
      else if (tick) begin
        if (m_rc[i] == 1) begin rep = 1'b1; m_rc[i] = RR; end
        else if (m_rc[i] > 1) m_rc[i] = m_rc[i] - 1;
      end
      if (pe || re) begin
        if (m_pv[i]) m_ovf = 1'b1;
        m_pv[i] = 1'b1;
        m_pt[i] = pe ? 2'b01 : 2'b10;
      end else if (rep && !m_pv[i]) begin
        m_pv[i] = 1'b1;
        m_pt[i] = 2'b11;
      end
    end
    if (clr_overflow) m_ovf = 1'b0;
    m_count = m_count + int'(push) - int'(pop);
    m_pressed = cur;
  endtask

  always @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) model_reset();
    else          model_step();
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge Clk) begin
    logic [9:0] e;
    if (Reset_n) begin
      check("evt_valid", 32'(evt_valid), 32'(m_count != 0));
      check("fifo_count", 32'(fifo_count), 32'(m_count));
      check("pressed", 32'(pressed), 32'(m_pressed));
      check("overflow", 32'(overflow), 32'(m_ovf));
      if (evt_valid && evt_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_event: got code %0h type %0h expected none", evt_code, evt_type);
        end else begin
          e = exp_q.pop_front();
          check("evt_code", 32'(evt_code), 32'(e[9:2]));
          check("evt_type", 32'(evt_type), 32'(e[1:0]));
          if (evt_type == 2'b11) n_rep++;
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge Clk);
      #2;
    end
  endtask

  logic [7:0] pool [9] = '{8'h00, 8'h1A, 8'h04, 8'h07, 8'h2C, 8'h28, 8'h16, 8'h29, 8'h55};

  initial begin
    int rep0, fcnt, fper, bias, s, waited;
    // index 2 is left unused (0x00)
    watch_codes = {8'h29, 8'h16, 8'h28, 8'h2C, 8'h07, 8'h00, 8'h04, 8'h1A};
    Reset_n = 1'b0; keycode = '0; frame_clk = 1'b0; evt_ready = 1'b0; clr_overflow = 1'b0;
    step(3);
    check("reset_evt_valid", 32'(evt_valid), 0);
    check("reset_evt_code", 32'(evt_code), 0);
    check("reset_evt_type", 32'(evt_type), 0);
    Reset_n = 1'b1;
    step(2);

    // single key press / release with latency checks
    evt_ready = 1'b1;
    keycode = 16'h001A;
    step(1);
    check("press_pressed0", 32'(pressed[0]), 1);
    check("press_not_yet_valid", 32'(evt_valid), 0);
    step(1);
    check("press_valid", 32'(evt_valid), 1);
    check("press_code", 32'(evt_code), 32'h1A);
    check("press_type", 32'(evt_type), 1);
    step(2);
    keycode = 16'h0000;
    step(2);
    check("release_code", 32'(evt_code), 32'h1A);
    check("release_type", 32'(evt_type), 2);
    step(3);

    // two keys at once: lower index first, on consecutive cycles
    keycode = 16'h0704;
    step(2);
    check("dual_first", 32'(evt_code), 32'h04);
    step(1);
    check("dual_second", 32'(evt_code), 32'h07);
    step(1);
    check("dual_drained", 32'(fifo_count), 0);
    keycode = 16'h0000;
    step(5);

    // auto-repeat across 8 frame ticks, none after release
    keycode = 16'h001A;
    step(2);
    rep0 = n_rep;
    for (int f = 0; f < 8; f++) begin
      frame_clk = 1'b1; step(4);
      frame_clk = 1'b0; step(4);
    end
    step(3);
    check("repeat_count", 32'(n_rep - rep0), 3);
    keycode = 16'h0000;
    for (int f = 0; f < 4; f++) begin
      frame_clk = 1'b1; step(4);
      frame_clk = 1'b0; step(4);
    end
    check("repeat_after_release", 32'(n_rep - rep0), 3);

    // fill FIFO with evt_ready low, then overwrite pending slots
    evt_ready = 1'b0;
    keycode = 16'h001A; step(3);
    keycode = 16'h0004; step(3);
    keycode = 16'h0007; step(3);
    keycode = 16'h002C; step(3);
    keycode = 16'h282C; step(3);
    check("full_count", 32'(fifo_count), 8);
    keycode = 16'h162C; step(3);
    check("pending_held_count", 32'(fifo_count), 8);
    check("no_overflow_yet", 32'(overflow), 0);
    keycode = 16'h282C; step(2);
    check("overflow_set", 32'(overflow), 1);
    check("still_full", 32'(fifo_count), 8);
    // full with pending: push and pop in the same cycle
    evt_ready = 1'b1;
    step(1);
    check("full_push_pop", 32'(fifo_count), 8);
    step(12);
    clr_overflow = 1'b1; step(1); clr_overflow = 1'b0;
    check("overflow_cleared", 32'(overflow), 0);
    keycode = 16'h0000;
    step(12);

    // randomized traffic with one mid-stream reset
    fcnt = 0; fper = 3; bias = 3;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = $urandom_range(0, 3);
      if ($urandom_range(0, 3) == 0) begin
        s = $urandom_range(0, NS - 1);
        keycode[8*s +: 8] = pool[$urandom_range(0, 8)];
      end
      evt_ready = ($urandom_range(0, 3) < bias);
      clr_overflow = ($urandom_range(0, 31) == 0);
      fcnt++;
      if (fcnt >= fper) begin
        fcnt = 0;
        fper = $urandom_range(2, 6);
        frame_clk = ~frame_clk;
      end
      if (c == 1500) begin
        Reset_n = 1'b0;
        #1;
        check("midreset_evt_valid", 32'(evt_valid), 0);
        check("midreset_pressed", 32'(pressed), 0);
        check("midreset_fifo_count", 32'(fifo_count), 0);
        check("midreset_overflow", 32'(overflow), 0);
        step(2);
        Reset_n = 1'b1;
      end
      step(1);
    end

    // drain everything, bounded
    keycode = '0; frame_clk = 1'b0; clr_overflow = 1'b0; evt_ready = 1'b1;
    waited = 0;
    while ((m_count != 0 || exp_q.size() != 0) && waited < 200) begin
      step(1);
      waited++;
    end
    step(4);
    check("drain_scoreboard_empty", 32'(exp_q.size()), 0);
    check("drain_fifo_count", 32'(fifo_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
